// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions.
// Used by both the write and read arbiters.
package axi_ic_pkg;

  localparam int DEF_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// Arbiter-side view of the write channel.
// slave: the arbiter; master: whoever drives requests.
interface axi_wr_arbiter_if #(
  parameter int LEN_W = 8
) ();

  logic             m0_awvalid;
  logic [LEN_W-1:0] m0_awlen;
  logic             m1_awvalid;
  logic [LEN_W-1:0] m1_awlen;
  logic             s_awready;
  logic             s_wvalid;
  logic             s_wready;
  logic             s_wlast;
  logic             s_bvalid;
  logic             s_bready;

  logic m0_gnt;
  logic m1_gnt;
  logic sel;
  logic aw_en;
  logic w_en;
  logic b_en;
  logic busy;
  logic len_err;

  modport slave (
    input  m0_awvalid, m0_awlen,
    input  m1_awvalid, m1_awlen,
    input  s_awready,
    input  s_wvalid, s_wready, s_wlast,
    input  s_bvalid, s_bready,
    output m0_gnt, m1_gnt, sel,
    output aw_en, w_en, b_en,
    output busy, len_err
  );

  modport master (
    output m0_awvalid, m0_awlen,
    output m1_awvalid, m1_awlen,
    output s_awready,
    output s_wvalid, s_wready, s_wlast,
    output s_bvalid, s_bready,
    input  m0_gnt, m1_gnt, sel,
    input  aw_en, w_en, b_en,
    input  busy, len_err
  );

endinterface

// File: rtl/axi_wr_arbiter_rr_pick2.sv
// Two-requester round-robin selector.
// On contention the requester that did not win last time is chosen.
module rr_pick2
  import axi_ic_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_last_i,
  output logic       gnt_idx_o,
  output logic       any_o
);

  assign any_o = |req_i;

  always_comb begin
    gnt_idx_o = M0;
    unique case (1'b1)
      (req_i == 2'b11): gnt_idx_o = ~rr_last_i;
      (req_i == 2'b10): gnt_idx_o = M1;
      default:          gnt_idx_o = M0;
    endcase
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI write arbiter: holds grant AW..B,
// rotates priority and checks W beats against AWLEN.
module axi_wr_arbiter
  import axi_ic_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi_wr_arbiter_if.slave     bus
);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic             err_q, err_d;

  logic pick;
  logic any;
  logic beat;

  rr_pick2 u_pick (
    .req_i     ({bus.m1_awvalid, bus.m0_awvalid}),
    .rr_last_i (rr_q),
    .gnt_idx_o (pick),
    .any_o     (any)
  );

  assign beat = bus.s_wvalid & bus.s_wready;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          sel_d   = pick;
          len_d   = pick ? bus.m1_awlen : bus.m0_awlen;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.s_awready) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (bus.s_wlast) begin
            if (cnt_q != len_q) err_d = 1'b1;
            state_d = ST_RESP;
          end else if (cnt_q == len_q) begin
            // the beat that should have been last lacked WLAST
            err_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (bus.s_bvalid & bus.s_bready) begin
          rr_d    = sel_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      sel_q   <= M0;
      len_q   <= '0;
      cnt_q   <= '0;
      rr_q    <= M1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.sel     = bus.busy & sel_q;
  assign bus.m0_gnt  = bus.busy & ~sel_q;
  assign bus.m1_gnt  = bus.busy & sel_q;
  assign bus.aw_en   = (state_q == ST_ADDR);
  assign bus.w_en    = (state_q == ST_DATA);
  assign bus.b_en    = (state_q == ST_RESP);
  assign bus.len_err = err_q;

endmodule
